// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI-lite read arbiter and its helpers.
package axil_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        RESP,
        DRAIN
    } arb_state_t;

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axil_rr_pick.sv
// Combinational round-robin search: first asserted request strictly after
// last_grant, wrapping around, so last_grant itself has lowest priority.
import axil_pkg::*;

module axil_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]                req,
    input  logic [idx_width(NUM_REQ)-1:0]     last_grant,
    output logic [idx_width(NUM_REQ)-1:0]     winner,
    output logic                              found
);

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [IDX_W-1:0] cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    // Candidate gi is the requester (last_grant + gi + 1) mod NUM_REQ.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = {1'b0, last_grant} + (IDX_W+1)'(gi + 1);
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ))
                                ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                : sum[IDX_W-1:0];
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                winner = cand_idx[k];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axil_read_arbiter.sv
// Round-robin arbiter sharing one AXI-lite read channel among NUM_REQ masters,
// one transaction in flight. Optional RESP timeout: AXIL_RD_ARB_TIMEOUT_EN.
import axil_pkg::*;

module axil_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                            axil_rd_arb_clk,
    input  logic                            axil_rd_arb_rst_n,
    input  logic [NUM_REQ-1:0]              s_arvalid,
    output logic [NUM_REQ-1:0]              s_arready,
    input  logic [NUM_REQ*ADDR_W-1:0]       s_araddr,
    input  logic [NUM_REQ*3-1:0]            s_arprot,
    output logic [NUM_REQ-1:0]              s_rvalid,
    input  logic [NUM_REQ-1:0]              s_rready,
    output logic [DATA_W-1:0]               s_rdata,
    output logic [1:0]                      s_rresp,
    output logic                            m_arvalid,
    input  logic                            m_arready,
    output logic [ADDR_W-1:0]               m_araddr,
    output logic [2:0]                      m_arprot,
    input  logic                            m_rvalid,
    output logic                            m_rready,
    input  logic [DATA_W-1:0]               m_rdata,
    input  logic [1:0]                      m_rresp,
    output logic [idx_width(NUM_REQ)-1:0]   grant_id,
`ifdef AXIL_RD_ARB_TIMEOUT_EN
    output logic                            timeout_err,
`endif
    output logic                            busy
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t         state_reg, state_next;
    logic [ADDR_W-1:0]  addr_reg;
    logic [2:0]         prot_reg;
    logic [IDX_W-1:0]   grant_reg;
    logic [IDX_W-1:0]   last_grant_reg;

    logic [IDX_W-1:0]   winner;
    logic               found;
    logic               accept;
    logic               timeout_hit;

    logic [ADDR_W-1:0]  req_addr [NUM_REQ];
    logic [2:0]         req_prot [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign req_addr[gi] = s_araddr[gi*ADDR_W +: ADDR_W];
            assign req_prot[gi] = s_arprot[gi*3 +: 3];
        end
    endgenerate

    axil_rr_pick #(
        .NUM_REQ    (NUM_REQ)
    ) u_pick (
        .req        (s_arvalid),
        .last_grant (last_grant_reg),
        .winner     (winner),
        .found      (found)
    );

`ifdef AXIL_RD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_reg;

    // Counts cycles spent in RESP; saturates at the last waiting cycle.
    always_ff @(posedge axil_rd_arb_clk or negedge axil_rd_arb_rst_n) begin
        if (!axil_rd_arb_rst_n) begin
            cnt_reg <= '0;
        end else if (state_reg == ADDR && m_arready) begin
            cnt_reg <= '0;
        end else if (state_reg == RESP && cnt_reg != CNT_W'(TIMEOUT - 1)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg == RESP) && !m_rvalid
                       && (cnt_reg == CNT_W'(TIMEOUT - 1));
    assign timeout_err = timeout_hit && s_rready[grant_reg];
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        s_arready  = '0;
        s_rvalid   = '0;
        s_rdata    = '0;
        s_rresp    = AXIL_RESP_OKAY;
        m_rready   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    accept            = 1'b1;
                    // Keep every output low while reset is held.
                    s_arready[winner] = axil_rd_arb_rst_n;
                    state_next        = ADDR;
                end
            end
            ADDR: begin
                if (m_arready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (timeout_hit) begin
                    // Synthesised error response; the real one is drained later.
                    s_rvalid[grant_reg] = 1'b1;
                    s_rresp             = AXIL_RESP_SLVERR;
                    if (s_rready[grant_reg]) begin
                        state_next = DRAIN;
                    end
                end else begin
                    s_rvalid[grant_reg] = m_rvalid;
                    s_rdata             = m_rdata;
                    s_rresp             = m_rresp;
                    m_rready            = s_rready[grant_reg];
                    if (m_rvalid && s_rready[grant_reg]) begin
                        state_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge axil_rd_arb_clk or negedge axil_rd_arb_rst_n) begin
        if (!axil_rd_arb_rst_n) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            prot_reg       <= '0;
            grant_reg      <= '0;
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg       <= req_addr[winner];
                prot_reg       <= req_prot[winner];
                grant_reg      <= winner;
                last_grant_reg <= winner;
            end
        end
    end

    assign m_arvalid = (state_reg == ADDR);
    assign m_araddr  = addr_reg;
    assign m_arprot  = prot_reg;
    assign grant_id  = grant_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_axil_read_arbiter.sv
// Scoreboard bench for axil_read_arbiter; the timeout scenario runs only when
// AXIL_RD_ARB_TIMEOUT_EN is defined.
module tb_axil_read_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   s_arvalid;
    logic [3:0]   s_arready;
    logic [127:0] s_araddr;
    logic [11:0]  s_arprot;
    logic [3:0]   s_rvalid;
    logic [3:0]   s_rready;
    logic [31:0]  s_rdata;
    logic [1:0]   s_rresp;
    logic         m_arvalid;
    logic         m_arready;
    logic [31:0]  m_araddr;
    logic [2:0]   m_arprot;
    logic         m_rvalid;
    logic         m_rready;
    logic [31:0]  m_rdata;
    logic [1:0]   m_rresp;
    logic [1:0]   grant_id;
    logic         busy;
`ifdef AXIL_RD_ARB_TIMEOUT_EN
    logic         timeout_err;
`endif

    axil_read_arbiter #(
        .NUM_REQ (4),
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .axil_rd_arb_clk   (clk),
        .axil_rd_arb_rst_n (rst_n),
        .s_arvalid         (s_arvalid),
        .s_arready         (s_arready),
        .s_araddr          (s_araddr),
        .s_arprot          (s_arprot),
        .s_rvalid          (s_rvalid),
        .s_rready          (s_rready),
        .s_rdata           (s_rdata),
        .s_rresp           (s_rresp),
        .m_arvalid         (m_arvalid),
        .m_arready         (m_arready),
        .m_araddr          (m_araddr),
        .m_arprot          (m_arprot),
        .m_rvalid          (m_rvalid),
        .m_rready          (m_rready),
        .m_rdata           (m_rdata),
        .m_rresp           (m_rresp),
        .grant_id          (grant_id),
`ifdef AXIL_RD_ARB_TIMEOUT_EN
        .timeout_err       (timeout_err),
`endif
        .busy              (busy)
    );

    typedef struct {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;
    int   ar_hs = 0;
    int   r_hs = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && m_arvalid && m_arready) ar_hs = ar_hs + 1;
        if (rst_n && m_rvalid && m_rready)   r_hs  = r_hs + 1;
    end

    function automatic logic [31:0] lane_addr(input int i);
        return 32'h0000_1000 + 32'(i) * 32'h10;
    endfunction

    function automatic logic [2:0] lane_prot(input int i);
        return 3'(i) ^ 3'b101;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes();
        for (int i = 0; i < 4; i++) begin
            s_araddr[i*32 +: 32] = lane_addr(i);
            s_arprot[i*3 +: 3]   = lane_prot(i);
        end
    endtask

    function automatic exp_t mk_exp(input int id, input logic [31:0] data, input logic [1:0] resp);
        exp_t e;
        e.id   = 2'(id);
        e.addr = lane_addr(id);
        e.prot = lane_prot(id);
        e.data = data;
        e.resp = resp;
        return e;
    endfunction

    // Plays the downstream slave for one transaction and reports what it saw.
    task automatic serve_one(
        input  int          ar_wait,
        input  int          r_wait,
        input  logic [31:0] data,
        input  logic [1:0]  resp,
        output logic [1:0]  o_id,
        output logic [31:0] o_addr,
        output logic [2:0]  o_prot,
        output logic [31:0] o_rdata,
        output logic [1:0]  o_rresp,
        output logic [3:0]  o_rvalid,
        output logic        o_stable,
        output logic        o_tmo,
        output int          o_cyc
    );
        int n;
        logic [31:0] a0;
        o_id = '0; o_addr = '0; o_prot = '0; o_rdata = '0; o_rresp = '0;
        o_rvalid = '0; o_stable = 1'b1; o_tmo = 1'b0; o_cyc = 0;
        n = 0;
        while (!m_arvalid && n < 50) begin
            tick();
            n++;
        end
        if (!m_arvalid) begin
            o_tmo = 1'b1;
            return;
        end
        a0 = m_araddr;
        m_arready = 1'b0;
        repeat (ar_wait) begin
            tick();
            if (!m_arvalid || m_araddr !== a0) o_stable = 1'b0;
        end
        m_arready = 1'b1;
        #1;
        o_id   = grant_id;
        o_addr = m_araddr;
        o_prot = m_arprot;
        o_cyc  = cyc;
        tick();
        m_arready = 1'b0;
        if (m_arvalid) o_stable = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = data;
        m_rresp  = resp;
        s_rready = '0;
        repeat (r_wait) begin
            #1;
            if (m_rready !== 1'b0) o_stable = 1'b0;
            tick();
        end
        s_rready = '1;
        #1;
        o_rdata  = s_rdata;
        o_rresp  = s_rresp;
        o_rvalid = s_rvalid;
        if (m_rready !== 1'b1) o_stable = 1'b0;
        tick();
        m_rvalid = 1'b0;
        m_rdata  = '0;
        s_rready = '0;
    endtask

    task automatic test_reset();
        s_arvalid = '1;
        tick();
        tick();
        total_cnt++; if (s_arready !== 4'b0) $display("FAIL reset_arready: got %b want 0000", s_arready); else pass_cnt++;
        total_cnt++; if (m_arvalid !== 1'b0) $display("FAIL reset_m_arvalid: got %b want 0", m_arvalid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d want 0", grant_id); else pass_cnt++;
        total_cnt++; if (m_araddr !== 32'h0) $display("FAIL reset_m_araddr: got %h want 0", m_araddr); else pass_cnt++;
        total_cnt++; if (s_rvalid !== 4'b0 || m_rready !== 1'b0) $display("FAIL reset_r_chan: got rvalid=%b rready=%b want 0", s_rvalid, m_rready); else pass_cnt++;
        s_arvalid = '0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] o_id; logic [31:0] o_addr; logic [2:0] o_prot; logic [31:0] o_rdata;
        logic [1:0] o_rresp; logic [3:0] o_rvalid; logic o_stable; logic o_tmo; int o_cyc;
        int first_cyc;
        exp_t e;
        int order [5] = '{0, 1, 2, 3, 0};
        set_lanes();
        first_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(mk_exp(order[k], 32'hC0DE_0000 + 32'(k), (k == 2) ? 2'b01 : 2'b00));
        end
        s_arvalid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            serve_one(0, 0, 32'hC0DE_0000 + 32'(k), (k == 2) ? 2'b01 : 2'b00,
                      o_id, o_addr, o_prot, o_rdata, o_rresp, o_rvalid, o_stable, o_tmo, o_cyc);
            if (k == 0) first_cyc = o_cyc;
            e = exp_q.pop_front();
            $display("txn rr id=%0d addr=%h rdata=%h rresp=%b", o_id, o_addr, o_rdata, o_rresp);
            total_cnt++; if (o_tmo) $display("FAIL rr_wait_arvalid: got no m_arvalid want m_arvalid within 50 cycles"); else pass_cnt++;
            total_cnt++; if (o_id !== e.id) $display("FAIL rr_grant: got %0d want %0d", o_id, e.id); else pass_cnt++;
            total_cnt++; if (o_addr !== e.addr || o_prot !== e.prot) $display("FAIL rr_addr: got %h/%0d want %h/%0d", o_addr, o_prot, e.addr, e.prot); else pass_cnt++;
            total_cnt++; if (o_rdata !== e.data || o_rresp !== e.resp) $display("FAIL rr_rdata: got %h/%b want %h/%b", o_rdata, o_rresp, e.data, e.resp); else pass_cnt++;
            total_cnt++; if (o_rvalid !== (4'b0001 << e.id)) $display("FAIL rr_rvalid_route: got %b want %b", o_rvalid, 4'b0001 << e.id); else pass_cnt++;
        end
        s_arvalid = '0;
        total_cnt++; if (o_cyc - first_cyc !== 12) $display("FAIL rr_throughput: got %0d cycles want 12", o_cyc - first_cyc); else pass_cnt++;
        tick();
    endtask

    task automatic test_single();
        logic [1:0] o_id; logic [31:0] o_addr; logic [2:0] o_prot; logic [31:0] o_rdata;
        logic [1:0] o_rresp; logic [3:0] o_rvalid; logic o_stable; logic o_tmo; int o_cyc;
        exp_t e;
        set_lanes();
        s_araddr[2*32 +: 32] = 32'h0000_0040;
        e = mk_exp(2, 32'hDEAD_BEEF, 2'b00);
        e.addr = 32'h0000_0040;
        exp_q.push_back(e);
        s_arvalid = 4'b0100;
        #1;
        total_cnt++; if (s_arready !== 4'b0100) $display("FAIL single_arready: got %b want 0100", s_arready); else pass_cnt++;
        tick();
        s_arvalid = '0;
        total_cnt++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h40) $display("FAIL single_next_cycle: got arvalid=%b addr=%h want 1/00000040", m_arvalid, m_araddr); else pass_cnt++;
        serve_one(0, 0, 32'hDEAD_BEEF, 2'b00,
                  o_id, o_addr, o_prot, o_rdata, o_rresp, o_rvalid, o_stable, o_tmo, o_cyc);
        e = exp_q.pop_front();
        $display("txn single id=%0d addr=%h rdata=%h rresp=%b", o_id, o_addr, o_rdata, o_rresp);
        total_cnt++; if (o_id !== e.id || o_addr !== e.addr) $display("FAIL single_grant: got %0d/%h want %0d/%h", o_id, o_addr, e.id, e.addr); else pass_cnt++;
        total_cnt++; if (o_rvalid !== 4'b0100 || o_rdata !== e.data || o_rresp !== e.resp) $display("FAIL single_resp: got %b/%h/%b want 0100/%h/%b", o_rvalid, o_rdata, o_rresp, e.data, e.resp); else pass_cnt++;
        tick();
    endtask

    task automatic test_backpressure();
        logic [1:0] o_id; logic [31:0] o_addr; logic [2:0] o_prot; logic [31:0] o_rdata;
        logic [1:0] o_rresp; logic [3:0] o_rvalid; logic o_stable; logic o_tmo; int o_cyc;
        int ar0, r0;
        exp_t e;
        set_lanes();
        exp_q.push_back(mk_exp(1, 32'h5A5A_1234, 2'b00));
        ar0 = ar_hs;
        r0  = r_hs;
        s_arvalid = 4'b0010;
        tick();
        s_arvalid = '0;
        serve_one(5, 4, 32'h5A5A_1234, 2'b00,
                  o_id, o_addr, o_prot, o_rdata, o_rresp, o_rvalid, o_stable, o_tmo, o_cyc);
        e = exp_q.pop_front();
        $display("txn bp id=%0d addr=%h rdata=%h rresp=%b", o_id, o_addr, o_rdata, o_rresp);
        total_cnt++; if (o_stable !== 1'b1) $display("FAIL bp_stable: got unstable want stable m_arvalid/m_araddr and m_rready low"); else pass_cnt++;
        total_cnt++; if (o_id !== e.id || o_addr !== e.addr) $display("FAIL bp_grant: got %0d/%h want %0d/%h", o_id, o_addr, e.id, e.addr); else pass_cnt++;
        total_cnt++; if (o_rvalid !== 4'b0010 || o_rdata !== e.data) $display("FAIL bp_resp: got %b/%h want 0010/%h", o_rvalid, o_rdata, e.data); else pass_cnt++;
        total_cnt++; if (ar_hs - ar0 !== 1 || r_hs - r0 !== 1) $display("FAIL bp_handshakes: got ar=%0d r=%0d want 1/1", ar_hs - ar0, r_hs - r0); else pass_cnt++;
        tick();
    endtask

    task automatic test_fairness();
        logic [1:0] o_id; logic [31:0] o_addr; logic [2:0] o_prot; logic [31:0] o_rdata;
        logic [1:0] o_rresp; logic [3:0] o_rvalid; logic o_stable; logic o_tmo; int o_cyc;
        exp_t e;
        set_lanes();
        exp_q.push_back(mk_exp(0, 32'hF000_0000, 2'b00));
        exp_q.push_back(mk_exp(3, 32'hF000_0003, 2'b00));
        exp_q.push_back(mk_exp(0, 32'hF000_0010, 2'b00));
        for (int k = 0; k < 3; k++) begin
            // First pass sets last_grant to 0; then req0 and req3 compete.
            s_arvalid = (k == 0) ? 4'b0001 : 4'b1001;
            e = exp_q.pop_front();
            serve_one(0, 0, e.data, e.resp,
                      o_id, o_addr, o_prot, o_rdata, o_rresp, o_rvalid, o_stable, o_tmo, o_cyc);
            if (k == 0) s_arvalid = '0;
            $display("txn fair id=%0d addr=%h rdata=%h rresp=%b", o_id, o_addr, o_rdata, o_rresp);
            total_cnt++; if (o_id !== e.id || o_addr !== e.addr) $display("FAIL fair_grant: got %0d/%h want %0d/%h", o_id, o_addr, e.id, e.addr); else pass_cnt++;
            total_cnt++; if (o_rdata !== e.data) $display("FAIL fair_rdata: got %h want %h", o_rdata, e.data); else pass_cnt++;
        end
        s_arvalid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [1:0] o_id; logic [31:0] o_addr; logic [2:0] o_prot; logic [31:0] o_rdata;
        logic [1:0] o_rresp; logic [3:0] o_rvalid; logic o_stable; logic o_tmo; int o_cyc;
        exp_t e;
        set_lanes();
        s_arvalid = 4'b0100;
        tick();
        s_arvalid = '0;
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rdata   = 32'hAAAA_5555;
        m_rresp   = 2'b00;
        s_rready  = '0;
        #1;
        total_cnt++; if (s_rvalid !== 4'b0100) $display("FAIL rstmid_pre_rvalid: got %b want 0100", s_rvalid); else pass_cnt++;
        s_arvalid = 4'b1001;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (s_arready !== 4'b0 || s_rvalid !== 4'b0) $display("FAIL rstmid_s_outputs: got arready=%b rvalid=%b want 0/0", s_arready, s_rvalid); else pass_cnt++;
        total_cnt++; if (m_arvalid !== 1'b0 || m_rready !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_ctrl: got arvalid=%b rready=%b busy=%b want 0", m_arvalid, m_rready, busy); else pass_cnt++;
        total_cnt++; if (grant_id !== 2'd0 || m_araddr !== 32'h0 || m_arprot !== 3'd0) $display("FAIL rstmid_regs: got %0d/%h/%0d want 0/0/0", grant_id, m_araddr, m_arprot); else pass_cnt++;
        total_cnt++; if (s_rdata !== 32'h0 || s_rresp !== 2'b00) $display("FAIL rstmid_rdata: got %h/%b want 0/00", s_rdata, s_rresp); else pass_cnt++;
        tick();
        m_rvalid = 1'b0;
        m_rdata  = '0;
        rst_n    = 1'b1;
        exp_q.push_back(mk_exp(0, 32'h0BAD_F00D, 2'b00));
        #1;
        total_cnt++; if (s_arready !== 4'b0001) $display("FAIL rstmid_first_grant: got %b want 0001", s_arready); else pass_cnt++;
        tick();
        s_arvalid = '0;
        serve_one(0, 0, 32'h0BAD_F00D, 2'b00,
                  o_id, o_addr, o_prot, o_rdata, o_rresp, o_rvalid, o_stable, o_tmo, o_cyc);
        e = exp_q.pop_front();
        $display("txn rstmid id=%0d addr=%h rdata=%h rresp=%b", o_id, o_addr, o_rdata, o_rresp);
        total_cnt++; if (o_id !== e.id || o_addr !== e.addr || o_rdata !== e.data) $display("FAIL rstmid_txn: got %0d/%h/%h want %0d/%h/%h", o_id, o_addr, o_rdata, e.id, e.addr, e.data); else pass_cnt++;
        tick();
    endtask

`ifdef AXIL_RD_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic early_bad;
        set_lanes();
        early_bad = 1'b0;
        s_arvalid = 4'b0010;
        tick();
        s_arvalid = '0;
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        s_rready  = '1;
        m_rvalid  = 1'b0;
        m_rdata   = 32'hFFFF_FFFF;
        for (int k = 1; k <= 16; k++) begin
            #1;
            if (k < 16) begin
                if (s_rvalid !== 4'b0 || timeout_err !== 1'b0) early_bad = 1'b1;
            end else begin
                total_cnt++; if (early_bad) $display("FAIL tmo_early: got response before cycle 16 want none"); else pass_cnt++;
                total_cnt++; if (s_rvalid !== 4'b0010 || s_rresp !== 2'b10) $display("FAIL tmo_resp: got %b/%b want 0010/10", s_rvalid, s_rresp); else pass_cnt++;
                total_cnt++; if (s_rdata !== 32'h0 || timeout_err !== 1'b1) $display("FAIL tmo_data_err: got %h/%b want 0/1", s_rdata, timeout_err); else pass_cnt++;
            end
            tick();
        end
        #1;
        total_cnt++; if (timeout_err !== 1'b0 || m_rready !== 1'b1 || busy !== 1'b1) $display("FAIL tmo_drain: got err=%b rready=%b busy=%b want 0/1/1", timeout_err, m_rready, busy); else pass_cnt++;
        m_rvalid = 1'b1;
        m_rdata  = 32'hBAD0_BAD0;
        #1;
        total_cnt++; if (s_rvalid !== 4'b0) $display("FAIL tmo_late_forwarded: got %b want 0000", s_rvalid); else pass_cnt++;
        tick();
        m_rvalid = 1'b0;
        m_rdata  = '0;
        s_rready = '0;
        $display("txn timeout id=1 late data absorbed");
        total_cnt++; if (busy !== 1'b0) $display("FAIL tmo_back_idle: got busy=%b want 0", busy); else pass_cnt++;
        tick();
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        s_arvalid = '0;
        s_araddr  = '0;
        s_arprot  = '0;
        s_rready  = '0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_fairness();
        test_reset_mid();
`ifdef AXIL_RD_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
